// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns the debounced button vector into discrete press/release events and
//   queues them in a small FIFO, presented on a valid/ready stream. Each
//   event is {rel, code[4:0]}: rel = 1 for a release, 0 for a press, and code
//   is the key index. A sticky overflow flag records edges that were merged
//   into an event that was still pending, and so were lost.
//
// Parameters
//   NUM_KEYS  number of button inputs (at most 32, the code field is 5 bits)
//   AW        FIFO address width, depth = 2**AW
//
// Ports
//   clk       system clock, all logic on posedge
//   RSTN      synchronous active-low reset
//   btn_ok    debounced button levels, 1 = pressed, synchronous to clk
//   ev_ready  consumer accepts the head event this cycle
//   ev_valid  FIFO non-empty, head event is on ev_data
//   ev_data   head event {rel, code}, 0 while the FIFO is empty
//   ev_count  number of queued events, 0..2**AW
//   overflow  sticky, set when an edge is lost
//   ovf_clr   clears overflow (a same-cycle set wins)
module key_event_queue #(
    parameter int unsigned NUM_KEYS = 20,
    parameter int unsigned AW       = 3
) (
    input  logic                clk,
    input  logic                RSTN,
    input  logic [NUM_KEYS-1:0] btn_ok,
    input  logic                ev_ready,
    output logic                ev_valid,
    output logic [5:0]          ev_data,
    output logic [AW:0]         ev_count,
    output logic                overflow,
    input  logic                ovf_clr
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [NUM_KEYS-1:0] prev;
    logic [NUM_KEYS-1:0] pend_press;
    logic [NUM_KEYS-1:0] pend_rel;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] fall;
    logic [NUM_KEYS-1:0] grant_p;
    logic [NUM_KEYS-1:0] grant_r;

    logic [5:0]          mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    logic                full;
    logic                push;
    logic                pop;
    logic                lost;
    logic [5:0]          grant_data;

    assign rise     = btn_ok & ~prev;
    assign fall     = ~btn_ok & prev;

    assign full     = (count == (AW+1)'(DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    assign ev_count = count;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

    // Fixed-priority arbiter: presses of keys 0..N-1, then releases of keys
    // 0..N-1. Putting presses first guarantees a key's press leaves before
    // its release when both are pending. No grant at all while full, even if
    // the head is popped this cycle.
    always_comb begin
        grant_p    = '0;
        grant_r    = '0;
        grant_data = '0;
        push       = 1'b0;
        if (!full) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (!push && pend_press[i]) begin
                    grant_p[i] = 1'b1;
                    grant_data = {1'b0, 5'(i)};
                    push       = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (!push && pend_rel[i]) begin
                    grant_r[i] = 1'b1;
                    grant_data = {1'b1, 5'(i)};
                    push       = 1'b1;
                end
            end
        end
    end

    // A new edge landing on a still-pending, ungranted bit merges into it.
    assign lost = (|(rise & pend_press & ~grant_p)) |
                  (|(fall & pend_rel   & ~grant_r));

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            prev       <= '0;
            pend_press <= '0;
            pend_rel   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            prev       <= btn_ok;
            pend_press <= (pend_press & ~grant_p) | rise;
            pend_rel   <= (pend_rel   & ~grant_r) | fall;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase

            if (lost) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RSTN && push) begin
            mem[wr_ptr] <= grant_data;
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
//   Directed-vector bench for key_event_queue. Each table row gives the
//   inputs for one clock cycle and the outputs expected just after that
//   cycle's rising edge. A hand-written sequence at the end measures the
//   edge-to-valid latency with a bounded wait.
module tb_key_event_queue;

    localparam int unsigned NK = 20;
    localparam int unsigned AW = 3;

    typedef struct {
        logic          rstn;
        logic [NK-1:0] btn;
        logic          ready;
        logic          clr;
        logic          valid;
        logic [5:0]    data;
        logic [AW:0]   count;
        logic          ovf;
    } vec_t;

    logic          clk;
    logic          RSTN;
    logic [NK-1:0] btn_ok;
    logic          ev_ready;
    logic          ev_valid;
    logic [5:0]    ev_data;
    logic [AW:0]   ev_count;
    logic          overflow;
    logic          ovf_clr;

    int unsigned passed;
    int unsigned total;
    vec_t        vecs[$];

    key_event_queue #(
        .NUM_KEYS (NK),
        .AW       (AW)
    ) dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .btn_ok   (btn_ok),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_count (ev_count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic v(input logic rstn, input logic [NK-1:0] btn, input logic ready,
                     input logic clr, input logic valid, input logic [5:0] data,
                     input logic [AW:0] count, input logic ovf);
        vec_t r;
        r.rstn  = rstn;
        r.btn   = btn;
        r.ready = ready;
        r.clr   = clr;
        r.valid = valid;
        r.data  = data;
        r.count = count;
        r.ovf   = ovf;
        vecs.push_back(r);
    endtask

    initial begin
        logic [NK-1:0] k_hi;
        logic [NK-1:0] k_mid;
        int            lat;

        passed   = 0;
        total    = 0;
        RSTN     = 1'b0;
        btn_ok   = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;

        k_hi  = 20'hFFC00;   // keys 10..19
        k_mid = 20'h3FC00;   // keys 10..17

        // Single tap of key 4: press then release, two cycles of latency.
        v(0, 20'h0,    0, 0, 0, 6'h00, 0, 0);
        v(1, 20'h10,   1, 0, 0, 6'h00, 0, 0);
        v(1, 20'h0,    1, 0, 1, 6'h04, 1, 0);
        v(1, 20'h0,    1, 0, 1, 6'h24, 1, 0);
        v(1, 20'h0,    1, 0, 0, 6'h00, 0, 0);

        // Keys 7 and 2 together: lower index first, presses before releases.
        v(1, 20'h84,   1, 0, 0, 6'h00, 0, 0);
        v(1, 20'h0,    1, 0, 1, 6'h02, 1, 0);
        v(1, 20'h0,    1, 0, 1, 6'h07, 1, 0);
        v(1, 20'h0,    1, 0, 1, 6'h22, 1, 0);
        v(1, 20'h0,    1, 0, 1, 6'h27, 1, 0);
        v(1, 20'h0,    1, 0, 0, 6'h00, 0, 0);

        // Ten presses while stalled: FIFO fills to 8, two stay pending.
        v(1, k_hi,     0, 0, 0, 6'h00, 0, 0);
        for (int i = 1; i <= 8; i++) v(1, k_hi, 0, 0, 1, 6'h0A, (AW+1)'(i), 0);
        v(1, k_hi,     0, 0, 1, 6'h0A, 8, 0);
        // Pop at full: no grant that cycle, grants resume next cycle.
        v(1, k_hi,     1, 0, 1, 6'h0B, 7, 0);
        v(1, k_hi,     1, 0, 1, 6'h0C, 7, 0);
        v(1, k_hi,     1, 0, 1, 6'h0D, 7, 0);
        for (int i = 0; i < 6; i++) v(1, k_hi, 1, 0, 1, 6'h0E + 6'(i), (AW+1)'(6 - i), 0);
        v(1, k_hi,     1, 0, 0, 6'h00, 0, 0);

        // Releases of keys 10..19; pop+grant at count 4 keeps the count.
        v(1, 20'h0,    0, 0, 0, 6'h00, 0, 0);
        for (int i = 1; i <= 4; i++) v(1, 20'h0, 0, 0, 1, 6'h2A, (AW+1)'(i), 0);
        v(1, 20'h0,    1, 0, 1, 6'h2B, 4, 0);
        v(1, 20'h0,    0, 0, 1, 6'h2B, 5, 0);
        for (int i = 0; i < 4; i++) v(1, 20'h0, 1, 0, 1, 6'h2C + 6'(i), 5, 0);
        for (int i = 0; i < 4; i++) v(1, 20'h0, 1, 0, 1, 6'h30 + 6'(i), (AW+1)'(4 - i), 0);
        v(1, 20'h0,    1, 0, 0, 6'h00, 0, 0);

        // Full FIFO, key 5 tapped twice while stalled -> overflow.
        v(1, k_mid,    0, 0, 0, 6'h00, 0, 0);
        for (int i = 1; i <= 8; i++) v(1, k_mid, 0, 0, 1, 6'h0A, (AW+1)'(i), 0);
        v(1, k_mid | 20'h20, 0, 0, 1, 6'h0A, 8, 0);
        v(1, k_mid,          0, 0, 1, 6'h0A, 8, 0);
        v(1, k_mid | 20'h20, 0, 0, 1, 6'h0A, 8, 1);
        v(1, k_mid,          0, 1, 1, 6'h0A, 8, 1);   // set beats clear
        v(1, k_mid,          0, 1, 1, 6'h0A, 8, 0);
        v(1, k_mid,    1, 0, 1, 6'h0B, 7, 0);
        v(1, k_mid,    1, 0, 1, 6'h0C, 7, 0);
        v(1, k_mid,    1, 0, 1, 6'h0D, 7, 0);
        for (int i = 0; i < 4; i++) v(1, k_mid, 1, 0, 1, 6'h0E + 6'(i), (AW+1)'(6 - i), 0);
        v(1, k_mid,    1, 0, 1, 6'h05, 2, 0);
        v(1, k_mid,    1, 0, 1, 6'h25, 1, 0);
        v(1, k_mid,    1, 0, 0, 6'h00, 0, 0);

        // Key 0 held through reset, then reset mid-queue discards everything.
        v(0, 20'h1,    0, 0, 0, 6'h00, 0, 0);
        v(0, 20'h1,    0, 0, 0, 6'h00, 0, 0);
        v(1, 20'h1,    0, 0, 0, 6'h00, 0, 0);
        v(1, 20'h7,    0, 0, 1, 6'h00, 1, 0);
        v(1, 20'h7,    0, 0, 1, 6'h00, 2, 0);
        v(0, 20'h7,    0, 0, 0, 6'h00, 0, 0);
        v(1, 20'h0,    0, 0, 0, 6'h00, 0, 0);
        v(1, 20'h0,    0, 0, 0, 6'h00, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            RSTN     = vecs[i].rstn;
            btn_ok   = vecs[i].btn;
            ev_ready = vecs[i].ready;
            ovf_clr  = vecs[i].clr;
            @(posedge clk);
            #1;
            chk("ev_valid", i, 32'(ev_valid), 32'(vecs[i].valid));
            chk("ev_data",  i, 32'(ev_data),  32'(vecs[i].data));
            chk("ev_count", i, 32'(ev_count), 32'(vecs[i].count));
            chk("overflow", i, 32'(overflow), 32'(vecs[i].ovf));
        end

        // Edge-to-valid latency for key 19 from an idle queue.
        @(negedge clk);
        btn_ok   = 20'h80000;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        lat      = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (ev_valid) begin
                lat = c;
                break;
            end
        end
        chk("latency",      -1, 32'(lat),      32'd2);
        chk("latency_data", -1, 32'(ev_data),  32'h13);
        chk("latency_cnt",  -1, 32'(ev_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
